// File: rtl/trig_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : trig_unit                                                  |
// | Description : Multi-channel trigger unit for the ADC capture path.       |
// |               Selects a channel, applies a Schmitt comparator on the     |
// |               chosen edge and runs an auto/normal/single trigger FSM     |
// |               with holdoff and auto-mode timeout forcing.                |
// | Options     : define TRIG_EXT_EN to add the synchronized ext_trig source |
// |               (selected by ch_sel == NUM_CH).                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module trig_unit #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     ADC_clk,
  input  logic                     sys_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic [DATA_W-1:0]        hyst,
  input  logic                     edge_sel,
  input  logic [1:0]               trig_mode,
  input  logic                     arm,
  input  logic [CNT_W-1:0]         timeout,
  input  logic [CNT_W-1:0]         holdoff,
`ifdef TRIG_EXT_EN
  input  logic                     ext_trig,
`endif
  output logic                     trig_flag,
  output logic                     trig_forced,
  output logic                     armed,
  output logic                     done
);

  localparam logic [1:0] c_MODE_AUTO   = 2'b00;
  localparam logic [1:0] c_MODE_NORMAL = 2'b01;
  localparam logic [1:0] c_MODE_SINGLE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_HOLDOFF = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] w_sel_data, r_data;
  logic [DATA_W:0]   w_diff, w_sum;
  logic [DATA_W-1:0] w_lo, w_hi;
  logic              w_q_nxt, r_q, r_q_d, w_event;
  logic [1:0]        r_mode_q;
  logic [SEL_W-1:0]  r_sel_q;
  logic              r_edge_q, w_cfg_change;
  logic [CNT_W-1:0]  r_to_cnt, r_ho_cnt;
  logic              w_to_clr, w_ho_clr, w_fire, w_forced;

  // Channel mux; any out-of-range select falls back to channel 0
  always_comb begin
    w_sel_data = ch_data[DATA_W-1:0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (ch_sel == SEL_W'(i)) w_sel_data = ch_data[i*DATA_W +: DATA_W];
    end
  end

  // Register the selected sample
  always_ff @(posedge ADC_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_data <= '0;
    else            r_data <= w_sel_data;
  end

  // Hysteresis thresholds, saturated at the ends of the sample range
  assign w_diff = {1'b0, trig_level} - {1'b0, hyst};
  assign w_sum  = {1'b0, trig_level} + {1'b0, hyst};
  assign w_lo   = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
  assign w_hi   = w_sum[DATA_W]  ? '1 : w_sum[DATA_W-1:0];

`ifdef TRIG_EXT_EN
  localparam logic [SEL_W-1:0] c_EXT_SEL = SEL_W'(NUM_CH);
  logic r_ext_s1, r_ext_s2;
  logic w_ext_sel;
  assign w_ext_sel = (ch_sel == c_EXT_SEL);

  // Two-flop synchronizer for the asynchronous external trigger
  always_ff @(posedge ADC_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
    end else begin
      r_ext_s1 <= ext_trig;
      r_ext_s2 <= r_ext_s1;
    end
  end
`endif

  // Schmitt comparator: next value of q for the selected edge polarity
  always_comb begin
    w_q_nxt = r_q;
    if (!edge_sel) begin
      if (r_data >= trig_level)  w_q_nxt = 1'b1;
      else if (r_data < w_lo)    w_q_nxt = 1'b0;
    end else begin
      if (r_data <= trig_level)  w_q_nxt = 1'b0;
      else if (r_data > w_hi)    w_q_nxt = 1'b1;
    end
`ifdef TRIG_EXT_EN
    if (w_ext_sel) w_q_nxt = r_ext_s2;
`endif
  end

  // Schmitt state and its one-cycle delay used for edge detection
  always_ff @(posedge ADC_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_q_d <= r_q;
    end
  end

  assign w_event = edge_sel ? (r_q_d & ~r_q) : (r_q & ~r_q_d);

  // Registered copies of the configuration used to spot a change
  always_ff @(posedge ADC_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode_q <= 2'b00;
      r_sel_q  <= '0;
      r_edge_q <= 1'b0;
    end else begin
      r_mode_q <= trig_mode;
      r_sel_q  <= ch_sel;
      r_edge_q <= edge_sel;
    end
  end

  assign w_cfg_change = (trig_mode != r_mode_q) || (ch_sel != r_sel_q) || (edge_sel != r_edge_q);

  // Next-state and trigger decision; a configuration change overrides everything.
  // The timeout compare uses the full count so the first ARMED cycle acts as the
  // re-arm cycle before timeout counted cycles elapse.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_forced    = 1'b0;
    w_to_clr    = 1'b0;
    w_ho_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((trig_mode == c_MODE_AUTO) || (trig_mode == c_MODE_NORMAL) ||
            ((trig_mode == c_MODE_SINGLE) && arm)) begin
          w_state_nxt = S_ARMED;
          w_to_clr    = 1'b1;
        end
      end
      S_ARMED: begin
        if (w_event) begin
          w_fire      = 1'b1;
          w_state_nxt = (trig_mode == c_MODE_SINGLE) ? S_DONE : S_HOLDOFF;
          w_ho_clr    = 1'b1;
        end else if ((trig_mode == c_MODE_AUTO) && (timeout != '0) && (r_to_cnt == timeout)) begin
          w_fire      = 1'b1;
          w_forced    = 1'b1;
          w_state_nxt = S_HOLDOFF;
          w_ho_clr    = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (r_ho_cnt >= holdoff) begin
          w_state_nxt = S_ARMED;
          w_to_clr    = 1'b1;
        end
      end
      S_DONE: begin
        if (arm) begin
          w_state_nxt = S_HOLDOFF;
          w_ho_clr    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_cfg_change) begin
      w_state_nxt = S_IDLE;
      w_fire      = 1'b0;
      w_forced    = 1'b0;
      w_to_clr    = 1'b1;
      w_ho_clr    = 1'b1;
    end
  end

  // State register and registered trigger pulse
  always_ff @(posedge ADC_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      trig_flag   <= 1'b0;
      trig_forced <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      trig_flag   <= w_fire;
      trig_forced <= w_forced;
    end
  end

  // Timeout counter runs in ARMED, holdoff counter runs in HOLDOFF
  always_ff @(posedge ADC_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_to_cnt <= '0;
      r_ho_cnt <= '0;
    end else begin
      if (w_to_clr)                 r_to_cnt <= '0;
      else if (r_state == S_ARMED)  r_to_cnt <= r_to_cnt + CNT_W'(1);
      if (w_ho_clr)                 r_ho_cnt <= '0;
      else if (r_state == S_HOLDOFF) r_ho_cnt <= r_ho_cnt + CNT_W'(1);
    end
  end

  assign armed = (r_state == S_ARMED);
  assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_trig_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_trig_unit                                               |
// | Description : Directed self-checking bench for trig_unit.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_trig_unit;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 2;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 32;

  logic                     ADC_clk = 1'b0;
  logic                     sys_rst_n = 1'b1;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [SEL_W-1:0]         ch_sel = '0;
  logic [DATA_W-1:0]        trig_level = '0;
  logic [DATA_W-1:0]        hyst = '0;
  logic                     edge_sel = 1'b0;
  logic [1:0]               trig_mode = 2'b11;
  logic                     arm = 1'b0;
  logic [CNT_W-1:0]         timeout = '0;
  logic [CNT_W-1:0]         holdoff = '0;
  logic                     trig_flag, trig_forced, armed, done;

  int checks   = 0;
  int failures = 0;

  trig_unit #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .ADC_clk(ADC_clk), .sys_rst_n(sys_rst_n), .ch_data(ch_data), .ch_sel(ch_sel),
    .trig_level(trig_level), .hyst(hyst), .edge_sel(edge_sel), .trig_mode(trig_mode),
    .arm(arm), .timeout(timeout), .holdoff(holdoff), .trig_flag(trig_flag),
    .trig_forced(trig_forced), .armed(armed), .done(done)
  );

  always #5 ADC_clk = ~ADC_clk;

  task automatic tick();
    @(posedge ADC_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick n cycles and return how many cycles showed trig_flag high
  task automatic count_pulses(input int n, output int np);
    np = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (trig_flag) np++;
    end
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic es, input logic [7:0] lvl,
                          input logic [7:0] hy, input logic [31:0] to, input logic [31:0] ho);
    sys_rst_n = 1'b0;
    ch_data = '0; ch_sel = '0; arm = 1'b0;
    trig_level = lvl; hyst = hy; edge_sel = es; trig_mode = mode;
    timeout = to; holdoff = ho;
    ticks(2);
    sys_rst_n = 1'b1;
    ticks(3);
  endtask

  task automatic test_reset();
    trig_mode = 2'b01; ch_data[7:0] = 8'd200; trig_level = 8'd100;
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({trig_flag, trig_forced, armed, done} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000", {trig_flag, trig_forced, armed, done});
    end
    do_reset(2'b11, 1'b0, 8'd100, 8'd10, 32'd0, 32'd0);
    arm = 1'b1; tick(); arm = 1'b0; ticks(3);
    checks++;
    if ({trig_flag, trig_forced, armed, done} !== 4'b0000) begin
      failures++; $display("FAIL disabled_idle got=%b exp=0000", {trig_flag, trig_forced, armed, done});
    end
  endtask

  task automatic test_rising();
    int np, at, nf;
    do_reset(2'b01, 1'b0, 8'd100, 8'd10, 32'd0, 32'd0);
    checks++;
    if (armed !== 1'b1) begin failures++; $display("FAIL normal_armed got=%b exp=1", armed); end
    np = 0; at = -1; nf = 0;
    for (int v = 80; v <= 120; v++) begin
      ch_data[7:0] = 8'(v);
      tick();
      if (trig_flag) begin np++; if (at < 0) at = v; if (trig_forced) nf++; end
    end
    for (int i = 0; i < 5; i++) begin tick(); if (trig_flag) np++; end
    checks++;
    if (np != 1) begin failures++; $display("FAIL rise_count got=%0d exp=1", np); end
    checks++;
    if (at != 102) begin failures++; $display("FAIL rise_latency got=%0d exp=102", at); end
    checks++;
    if (nf != 0) begin failures++; $display("FAIL rise_forced got=%0d exp=0", nf); end
  endtask

  task automatic test_hysteresis();
    int np, np2, at;
    np = 0;
    for (int i = 0; i < 20; i++) begin ch_data[7:0] = i[0] ? 8'd101 : 8'd98;  tick(); if (trig_flag) np++; end
    for (int i = 0; i < 20; i++) begin ch_data[7:0] = i[0] ? 8'd101 : 8'd95;  tick(); if (trig_flag) np++; end
    for (int i = 0; i < 20; i++) begin ch_data[7:0] = i[0] ? 8'd101 : 8'd90;  tick(); if (trig_flag) np++; end
    checks++;
    if (np != 0) begin failures++; $display("FAIL hyst_no_retrigger got=%0d exp=0", np); end
    ch_data[7:0] = 8'd89;
    ticks(4);
    ch_data[7:0] = 8'd100;
    np2 = 0; at = -1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (trig_flag) begin np2++; if (at < 0) at = j; end
    end
    checks++;
    if (np2 != 1 || at != 3) begin
      failures++; $display("FAIL hyst_retrigger got=%0d@%0d exp=1@3", np2, at);
    end
  endtask

  task automatic test_falling();
    int np, at;
    do_reset(2'b01, 1'b1, 8'd100, 8'd10, 32'd0, 32'd0);
    ch_data[7:0] = 8'd120;
    count_pulses(5, np);
    at = -1;
    for (int v = 119; v >= 90; v--) begin
      ch_data[7:0] = 8'(v);
      tick();
      if (trig_flag) begin np++; if (at < 0) at = v; end
    end
    checks++;
    if (np != 1 || at != 98) begin failures++; $display("FAIL fall_pulse got=%0d@%0d exp=1@98", np, at); end
  endtask

  task automatic test_saturation();
    int np, n1;
    do_reset(2'b01, 1'b0, 8'd5, 8'd10, 32'd0, 32'd0);
    ch_data[7:0] = 8'd10; count_pulses(6, np);
    ch_data[7:0] = 8'd0;  count_pulses(5, n1); np += n1;
    ch_data[7:0] = 8'd10; count_pulses(6, n1); np += n1;
    checks++;
    if (np != 1) begin failures++; $display("FAIL sat_sub got=%0d exp=1", np); end
    do_reset(2'b01, 1'b1, 8'd250, 8'd10, 32'd0, 32'd0);
    np = 0;
    for (int r = 0; r < 2; r++) begin
      ch_data[7:0] = 8'd255; count_pulses(6, n1); np += n1;
      ch_data[7:0] = 8'd0;   count_pulses(6, n1); np += n1;
    end
    checks++;
    if (np != 0) begin failures++; $display("FAIL sat_add got=%0d exp=0", np); end
  endtask

  task automatic test_channel_select();
    int np;
    do_reset(2'b01, 1'b0, 8'd100, 8'd10, 32'd0, 32'd0);
    ch_sel = 2'd1; ticks(3);
    ch_data[7:0] = 8'd150; count_pulses(6, np);
    checks++;
    if (np != 0) begin failures++; $display("FAIL sel1_ignores_ch0 got=%0d exp=0", np); end
    ch_data[15:8] = 8'd150; count_pulses(6, np);
    checks++;
    if (np != 1) begin failures++; $display("FAIL sel1_ch1 got=%0d exp=1", np); end
    ch_data = '0; ch_sel = 2'd3; ticks(4);
    ch_data[15:8] = 8'd150; count_pulses(6, np);
    checks++;
    if (np != 0) begin failures++; $display("FAIL sel3_ignores_ch1 got=%0d exp=0", np); end
    ch_data[7:0] = 8'd150; count_pulses(6, np);
    checks++;
    if (np != 1) begin failures++; $display("FAIL sel3_uses_ch0 got=%0d exp=1", np); end
  endtask

  task automatic test_auto();
    int t[4];
    int n, nonforced, w, np;
    do_reset(2'b00, 1'b0, 8'd100, 8'd10, 32'd50, 32'd0);
    n = 0; nonforced = 0;
    for (int c = 1; c <= 250; c++) begin
      tick();
      if (trig_flag) begin
        if (n < 4) t[n] = c;
        n++;
        if (!trig_forced) nonforced++;
      end
    end
    checks++;
    if (n < 4) begin failures++; $display("FAIL auto_count got=%0d exp>=4", n); end
    else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (t[k] - t[k-1] != 52) begin
          failures++; $display("FAIL auto_period got=%0d exp=52", t[k] - t[k-1]);
        end
      end
    end
    checks++;
    if (nonforced != 0) begin failures++; $display("FAIL auto_forced got=%0d unforced exp=0", nonforced); end
    // Align a real event with the cycle the timeout expires
    w = 0;
    while (!trig_flag && w < 60) begin tick(); w++; end
    checks++;
    if (w >= 60) begin failures++; $display("FAIL auto_wait got=timeout exp=pulse"); end
    ticks(49);
    ch_data[7:0] = 8'd200;
    ticks(3);
    checks++;
    if ({trig_flag, trig_forced} !== 2'b10) begin
      failures++; $display("FAIL event_beats_timeout got=%b exp=10", {trig_flag, trig_forced});
    end
    ch_data[7:0] = 8'd0;
    timeout = 32'd0;
    count_pulses(150, np);
    checks++;
    if (np != 0) begin failures++; $display("FAIL timeout_zero got=%0d exp=0", np); end
  endtask

  task automatic test_holdoff();
    int t[8];
    int n, p, lowlen;
    do_reset(2'b01, 1'b0, 8'd100, 8'd10, 32'd0, 32'd200);
    n = 0; p = -1; lowlen = -1;
    for (int c = 0; c < 900; c++) begin
      ch_data[7:0] = ((c / 20) % 2 == 1) ? 8'd50 : 8'd120;
      tick();
      if (trig_flag) begin
        if (n < 8) t[n] = c;
        if (n == 0) p = c;
        n++;
      end
      if (p >= 0 && lowlen < 0 && armed) lowlen = c - p;
    end
    checks++;
    if (lowlen != 201) begin failures++; $display("FAIL holdoff_length got=%0d exp=201", lowlen); end
    checks++;
    if (n < 3) begin failures++; $display("FAIL holdoff_count got=%0d exp>=3", n); end
    for (int k = 1; k < n && k < 8; k++) begin
      checks++;
      if (t[k] - t[k-1] < 202 || t[k] - t[k-1] > 243) begin
        failures++; $display("FAIL holdoff_spacing got=%0d exp=202..243", t[k] - t[k-1]);
      end
    end
  endtask

  task automatic test_single();
    int np, n1;
    do_reset(2'b10, 1'b0, 8'd100, 8'd10, 32'd0, 32'd0);
    checks++;
    if ({armed, done} !== 2'b00) begin failures++; $display("FAIL single_wait got=%b exp=00", {armed, done}); end
    arm = 1'b1; tick(); arm = 1'b0;
    checks++;
    if (armed !== 1'b1) begin failures++; $display("FAIL single_arm got=%b exp=1", armed); end
    ch_data[7:0] = 8'd150; count_pulses(6, np);
    checks++;
    if (np != 1 || {armed, done} !== 2'b01) begin
      failures++; $display("FAIL single_fire got=%0d/%b exp=1/01", np, {armed, done});
    end
    ch_data[7:0] = 8'd0;   count_pulses(4, np);
    ch_data[7:0] = 8'd150; count_pulses(6, n1); np += n1;
    checks++;
    if (np != 0 || done !== 1'b1) begin failures++; $display("FAIL single_hold got=%0d/%b exp=0/1", np, done); end
    arm = 1'b1; tick(); arm = 1'b0;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL single_rearm_done got=%b exp=0", done); end
    tick();
    checks++;
    if (armed !== 1'b1) begin failures++; $display("FAIL single_rearm got=%b exp=1", armed); end
    ch_data[7:0] = 8'd0; ticks(3);
    ch_data[7:0] = 8'd150; count_pulses(6, np);
    checks++;
    if (np != 1 || done !== 1'b1) begin failures++; $display("FAIL single_refire got=%0d/%b exp=1/1", np, done); end
  endtask

  task automatic test_mode_change();
    int w, n;
    // Counter cleared by a select change in the middle of the ARMED count
    do_reset(2'b00, 1'b0, 8'd100, 8'd10, 32'd50, 32'd0);
    w = 0;
    while (!trig_flag && w < 60) begin tick(); w++; end
    checks++;
    if (w >= 60) begin failures++; $display("FAIL chg_wait got=timeout exp=pulse"); end
    ticks(31);
    ch_sel = 2'd1;
    tick();
    checks++;
    if ({trig_flag, armed} !== 2'b00) begin failures++; $display("FAIL chg_idle got=%b exp=00", {trig_flag, armed}); end
    tick();
    n = 0;
    while (!trig_flag && n < 100) begin tick(); n++; end
    checks++;
    if (n != 51 || trig_forced !== 1'b1) begin
      failures++; $display("FAIL chg_counter_cleared got=%0d/%b exp=51/1", n, trig_forced);
    end
    // arm arriving together with a configuration change is dropped
    do_reset(2'b10, 1'b0, 8'd100, 8'd10, 32'd0, 32'd0);
    arm = 1'b1; edge_sel = 1'b1; tick(); arm = 1'b0; tick();
    checks++;
    if (armed !== 1'b0) begin failures++; $display("FAIL arm_vs_change got=%b exp=0", armed); end
    arm = 1'b1; tick(); arm = 1'b0;
    checks++;
    if (armed !== 1'b1) begin failures++; $display("FAIL arm_after_change got=%b exp=1", armed); end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset(2'b01, 1'b0, 8'd100, 8'd10, 32'd0, 32'd200);
    ch_data[7:0] = 8'd150;
    w = 0;
    while (!trig_flag && w < 20) begin tick(); w++; end
    checks++;
    if (w >= 20) begin failures++; $display("FAIL rst_wait got=timeout exp=pulse"); end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({trig_flag, trig_forced, armed, done} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_holdoff got=%b exp=0000", {trig_flag, trig_forced, armed, done});
    end
    ch_data[7:0] = 8'd0;
    ticks(2); sys_rst_n = 1'b1; ticks(3);
    checks++;
    if (armed !== 1'b1) begin failures++; $display("FAIL rst_rearm got=%b exp=1", armed); end
    ticks(10);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (armed !== 1'b0) begin failures++; $display("FAIL rst_mid_armed got=%b exp=0", armed); end
    ticks(2); sys_rst_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_rising();
    test_hysteresis();
    test_falling();
    test_saturation();
    test_channel_select();
    test_auto();
    test_holdoff();
    test_single();
    test_mode_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
